// File: rtl/apb_req_bridge.sv
// apb_req_bridge: turns one req/gnt data-channel request into a single APB3 master transfer.
// One access outstanding at a time; partial-byte writes and stalled slaves are reported back as errors.
module apb_req_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        data_req_i,
  output logic                        data_gnt_o,
  input  logic                        data_we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic                        psel_o,
  output logic                        penable_o,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  localparam int unsigned BE_W  = APB_DATA_WIDTH / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [APB_ADDR_WIDTH-1:0] paddr_nxt;
  logic [APB_DATA_WIDTH-1:0] pwdata_nxt;
  logic                      pwrite_nxt;
  logic                      psel_nxt;
  logic                      penable_nxt;
  logic                      rvalid_nxt;
  logic [APB_DATA_WIDTH-1:0] rdata_nxt;
  logic                      err_nxt;

  // Grant is the only combinational output; held low while reset is asserted.
  assign data_gnt_o = data_req_i & (state == IDLE) & ~rst_i;

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    paddr_nxt   = paddr_o;
    pwdata_nxt  = pwdata_o;
    pwrite_nxt  = pwrite_o;
    psel_nxt    = 1'b0;
    penable_nxt = 1'b0;
    rvalid_nxt  = 1'b0;
    rdata_nxt   = '0;
    err_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (data_gnt_o) begin
          // Word-align silently by clearing the byte offset.
          paddr_nxt  = data_addr_i & ~APB_ADDR_WIDTH'(3);
          pwdata_nxt = data_wdata_i;
          pwrite_nxt = data_we_i;
          cnt_nxt    = '0;
          if (data_we_i && (data_be_i != {BE_W{1'b1}})) begin
            // APB3 has no strobes: partial writes are refused without a bus access.
            state_nxt  = RESP;
            rvalid_nxt = 1'b1;
            err_nxt    = 1'b1;
          end else begin
            state_nxt = SETUP;
            psel_nxt  = 1'b1;
          end
        end
      end

      SETUP: begin
        state_nxt   = ACCESS;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
      end

      ACCESS: begin
        if (pready_i) begin
          // Completion takes priority over a timeout expiring in the same cycle.
          state_nxt  = RESP;
          rvalid_nxt = 1'b1;
          rdata_nxt  = pwrite_o ? '0 : prdata_i;
          err_nxt    = pslverr_i;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt  = RESP;
          rvalid_nxt = 1'b1;
          err_nxt    = 1'b1;
          cnt_nxt    = CNT_W'(TIMEOUT_CYCLES);
        end else begin
          psel_nxt    = 1'b1;
          penable_nxt = 1'b1;
          cnt_nxt     = cnt + CNT_W'(1);
        end
      end

      RESP: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, timeout counter and registered outputs; reset aborts any transfer immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pwrite_o      <= 1'b0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      paddr_o       <= paddr_nxt;
      pwdata_o      <= pwdata_nxt;
      pwrite_o      <= pwrite_nxt;
      psel_o        <= psel_nxt;
      penable_o     <= penable_nxt;
      data_rvalid_o <= rvalid_nxt;
      data_rdata_o  <= rdata_nxt;
      data_err_o    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Bench for apb_req_bridge: requester driver, APB slave model, response scoreboard.
module tb_apb_req_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [3:0]    data_be = 4'hF;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_gnt;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          data_err;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb_req_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .data_req_i(data_req),
    .data_gnt_o(data_gnt),
    .data_we_i(data_we),
    .data_be_i(data_be),
    .data_addr_i(data_addr),
    .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata),
    .data_err_o(data_err),
    .paddr_o(paddr),
    .pwdata_o(pwdata),
    .pwrite_o(pwrite),
    .psel_o(psel),
    .penable_o(penable),
    .prdata_i(prdata),
    .pready_i(pready),
    .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            gcyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Current transfer as seen by the slave model and the stability checks.
  int            cur_waits = 0;
  logic [DW-1:0] cur_prdata = '0;
  logic          cur_slv = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_we = 1'b0;
  int            acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: response content and grant-to-rvalid latency from the transfer rules.
  function automatic exp_t model(input logic we, input logic [3:0] be, input int waits,
                                 input logic [DW-1:0] prd, input logic slv);
    exp_t e;
    if (we && be != 4'hF) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 1;
    end else if (waits >= int'(TO)) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 2 + int'(TO);
    end else begin
      e.rdata = we ? '0 : prd; e.err = slv; e.lat = 3 + waits;
    end
    e.gcyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor plus APB slave: pops the scoreboard on rvalid, checks bus stability, drives pready.
  always @(negedge clk) begin
    if (rst) begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc_cnt = 0;
    end else begin
      checks = checks + 1;
      if (data_rvalid) begin
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL spurious_rvalid: got rvalid=1 rdata=%h err=%b expected no response",
                   data_rdata, data_err);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (data_rdata !== e.rdata || data_err !== e.err || (cyc - e.gcyc) != e.lat) begin
            errors = errors + 1;
            $display("FAIL response: got rdata=%h err=%b lat=%0d expected rdata=%h err=%b lat=%0d",
                     data_rdata, data_err, cyc - e.gcyc, e.rdata, e.err, e.lat);
          end
        end
      end else if (data_rdata !== '0 || data_err !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL idle_resp: got rdata=%h err=%b expected 0 0", data_rdata, data_err);
      end
      checks = checks + 1;
      if (penable && !psel) begin
        errors = errors + 1;
        $display("FAIL penable_no_psel: got penable=1 psel=0 expected psel=1");
      end
      if (psel) begin
        checks = checks + 1;
        if (paddr !== exp_addr || pwrite !== exp_we || pwdata !== exp_wdata) begin
          errors = errors + 1;
          $display("FAIL apb_bus: got addr=%h we=%b wdata=%h expected addr=%h we=%b wdata=%h",
                   paddr, pwrite, pwdata, exp_addr, exp_we, exp_wdata);
        end
      end
      if (psel && penable) begin
        pready  = (acc_cnt == cur_waits);
        prdata  = pready ? cur_prdata : $urandom;
        pslverr = pready ? cur_slv : 1'b0;
        acc_cnt = acc_cnt + 1;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'b0;
        acc_cnt = 0;
      end
    end
  end

  // Present a request and wait (bounded) for its grant; req is left high for the caller.
  task automatic do_req(input logic we, input logic [3:0] be, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int waits, input logic [DW-1:0] prd,
                        input logic slv, input bit push, output int g);
    exp_t e;
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wdata;
    g = -1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (data_gnt) begin
        chk("gnt_only_idle", {61'd0, psel, penable, data_rvalid}, 64'd0);
        cur_waits  = waits;
        cur_prdata = prd;
        cur_slv    = slv;
        exp_addr   = {addr[AW-1:2], 2'b00};
        exp_wdata  = wdata;
        exp_we     = we;
        g = cyc;
        if (push) begin
          e = model(we, be, waits, prd, slv);
          e.gcyc = cyc;
          sb.push_back(e);
        end
        break;
      end
      @(negedge clk);
    end
    if (g < 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL gnt_timeout: got no grant expected grant within 60 cycles");
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int g1, g2;
    data_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", {63'd0, data_gnt}, 64'd0);
    chk("rst_apb", {61'd0, psel, penable, pwrite}, 64'd0);
    chk("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
    chk("rst_resp", {31'd0, data_rvalid, data_rdata}, 64'd0);
    data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read, slow write, read with slave error, partial write.
    do_req(1'b0, 4'hF, 32'h1A10_0004, 32'h0, 0, 32'hCAFE_0001, 1'b0, 1'b1, g1);
    data_req = 1'b0;
    do_req(1'b1, 4'hF, 32'h1A10_1000, 32'h0000_00FF, 2, 32'h5555_AAAA, 1'b0, 1'b1, g1);
    data_req = 1'b0;
    do_req(1'b0, 4'h0, 32'h1A10_2008, 32'h0, 1, 32'h1234_5678, 1'b1, 1'b1, g1);
    data_req = 1'b0;
    do_req(1'b1, 4'b0011, 32'h1A10_3000, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 1'b1, g1);
    data_req = 1'b0;

    // Timeout abort, then the next request is granted in the first IDLE cycle.
    do_req(1'b0, 4'hF, 32'h1A10_4000, 32'h0, 50, 32'h7777_7777, 1'b0, 1'b1, g1);
    do_req(1'b0, 4'hF, 32'h1A10_4004, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b1, g2);
    chk("gnt_after_timeout", 64'(g2 - g1), 64'(3 + TO));
    data_req = 1'b0;

    // Ready on the last allowed cycle completes; unaligned address is dropped to a word.
    do_req(1'b0, 4'hF, 32'h1A10_5003, 32'h0, int'(TO) - 1, 32'hA5A5_0003, 1'b0, 1'b1, g1);
    data_req = 1'b0;

    // Back-to-back reads with req held high.
    do_req(1'b0, 4'hF, 32'h1A10_6000, 32'h0, 0, 32'h1111_1111, 1'b0, 1'b1, g1);
    do_req(1'b0, 4'hF, 32'h1A10_6004, 32'h0, 0, 32'h2222_2222, 1'b0, 1'b1, g2);
    chk("b2b_gnt_spacing", 64'(g2 - g1), 64'd4);
    data_req = 1'b0;

    // Reset in the middle of ACCESS: bus drops at once, no response.
    do_req(1'b0, 4'hF, 32'h1A10_7000, 32'h0, 20, 32'h3333_3333, 1'b0, 1'b0, g1);
    data_req = 1'b0;
    @(negedge clk);
    #1;
    chk("in_access", {62'd0, psel, penable}, 64'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_drop", {61'd0, psel, penable, data_rvalid}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 4'hF, 32'h1A10_8000, 32'h0, 1, 32'h4444_4444, 1'b0, 1'b1, g1);
    data_req = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      logic we;
      logic [3:0] be;
      int gap;
      we  = 1'($urandom_range(0, 1));
      be  = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
      gap = $urandom_range(0, 2);
      do_req(we, be, $urandom, $urandom, $urandom_range(0, 6), $urandom,
             1'($urandom_range(0, 3) == 0), 1'b1, g1);
      if (gap > 0) begin
        data_req = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    data_req = 1'b0;

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
